// File: rtl/jtsdram_test_seq.sv
// Test sequencer for the SDRAM verification core: pulses bank checker starts in
// parallel or serial passes and gathers pass count, sticky errors and watchdog status.
module jtsdram_test_seq #(
    parameter int BANKS = 4,
    parameter int PW    = 8,
    parameter int TW    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             serial,
    input  logic             halt_on_err,
    input  logic [BANKS-1:0] bank_done,
    input  logic [BANKS-1:0] bank_bad,
    output logic [BANKS-1:0] bank_start,
    output logic             slow,
    output logic             busy,
    output logic [2:0]       cur_bank,
    output logic [PW-1:0]    pass_cnt,
    output logic [BANKS-1:0] bad_mask,
    output logic             timeout,
    output logic [2:0]       state_dbg
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        GUARD = 3'd2,
        WAIT  = 3'd3,
        NEXT  = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [2:0] LAST = 3'(BANKS - 1);

    state_t           state;
    logic             mode;
    logic             new_err;
    logic [TW-1:0]    wdog;
    logic [TW-1:0]    wdog_nxt;
    logic [BANKS-1:0] sel;
    logic [BANKS-1:0] hits;
    logic             complete;

    function automatic logic [BANKS-1:0] onehot(input logic [2:0] b);
        logic [BANKS-1:0] v;
        for (int i = 0; i < BANKS; i++) v[i] = (b == 3'(i));
        return v;
    endfunction

    // Checker handshake: a one-cycle start pulse restarts a checker, which drops done
    // on that edge and later raises done as a level with bad already valid beside it.
    always_comb begin
        sel      = mode ? onehot(cur_bank) : {BANKS{1'b1}};
        complete = &(bank_done | ~sel);
        hits     = bank_bad & sel;
        wdog_nxt = wdog + TW'(1);
    end

    assign busy      = (state != IDLE) && (state != HALT);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode       <= 1'b0;
            new_err    <= 1'b0;
            wdog       <= '0;
            bank_start <= '0;
            slow       <= 1'b0;
            cur_bank   <= 3'd0;
            pass_cnt   <= '0;
            bad_mask   <= '0;
            timeout    <= 1'b0;
        end else begin
            bank_start <= '0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        mode       <= serial;
                        cur_bank   <= 3'd0;
                        new_err    <= 1'b0;
                        bank_start <= serial ? onehot(3'd0) : {BANKS{1'b1}};
                        state      <= START;
                    end
                end
                START: begin
                    wdog  <= '0;
                    state <= GUARD;
                end
                // Checkers clear done on the start edge, so done seen here may be stale.
                GUARD: state <= WAIT;
                WAIT: begin
                    if (complete) begin
                        bad_mask <= bad_mask | hits;
                        if ((hits & ~bad_mask) != '0) new_err <= 1'b1;
                        state <= NEXT;
                    end else if (wdog_nxt == {TW{1'b1}}) begin
                        wdog    <= wdog_nxt;
                        timeout <= 1'b1;
                        state   <= HALT;
                    end else begin
                        wdog <= wdog_nxt;
                    end
                end
                NEXT: begin
                    if (mode && (cur_bank < LAST)) begin
                        cur_bank   <= cur_bank + 3'd1;
                        bank_start <= onehot(cur_bank + 3'd1);
                        state      <= START;
                    end else begin
                        if (pass_cnt != {PW{1'b1}}) pass_cnt <= pass_cnt + PW'(1);
                        slow     <= ~slow;
                        cur_bank <= 3'd0;
                        new_err  <= 1'b0;
                        if (halt_on_err && new_err) begin
                            state <= HALT;
                        end else if (enable) begin
                            bank_start <= mode ? onehot(3'd0) : {BANKS{1'b1}};
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HALT: begin
                    if (!enable) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
